// File: rtl/tl_ul_sram_responder.sv
// ---------------------------------------------------------------------------
// tl_ul_sram_responder
//
// TileLink-UL manager endpoint backed by an internal word-addressed RAM.
// Accepts Get, PutFullData and PutPartialData (single or multi-beat bursts on
// a 32-bit bus) and answers every request on the D channel. Requests that
// are out of range, misaligned, oversized or use an unsupported opcode are
// answered with a denied response and leave memory untouched.
//
// Parameters
//   BASE_ADDR    byte base address of the region
//   DEPTH_WORDS  number of 32-bit words (power of 2)
//   MAX_SIZE     largest accepted lg2 transfer size
//
// Ports
//   clock                    rising-edge clock
//   reset                    asynchronous active-low reset
//   auto_in_a_*              TL-UL A channel (request), a_ready is an output
//   auto_in_d_*              TL-UL D channel (response), d_ready is an input
// ---------------------------------------------------------------------------
module tl_ul_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          MAX_SIZE    = 6
) (
    input  logic        clock,
    input  logic        reset,
    output logic        auto_in_a_ready,
    input  logic        auto_in_a_valid,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [3:0]  auto_in_a_bits_size,
    input  logic [3:0]  auto_in_a_bits_source,
    input  logic [31:0] auto_in_a_bits_address,
    input  logic [3:0]  auto_in_a_bits_mask,
    input  logic [31:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    input  logic        auto_in_d_ready,
    output logic        auto_in_d_valid,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [3:0]  auto_in_d_bits_size,
    output logic [3:0]  auto_in_d_bits_source,
    output logic        auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [31:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);

    localparam int IW = $clog2(DEPTH_WORDS);
    // Last byte address belonging to the region, in 34 bits so that a region
    // ending at the top of the 32-bit space cannot wrap.
    localparam logic [33:0] REGION_LAST = {2'b00, BASE_ADDR} + 34'(4 * DEPTH_WORDS) - 34'd1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PUT_BURST = 2'd1,
        S_RESP      = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;       // beats remaining after the current one
    logic [IW-1:0]  idx_q, idx_d;       // word index of the next beat
    logic [3:0]     source_q, source_d;
    logic [3:0]     size_q, size_d;
    logic           is_get_q, is_get_d;
    logic           denied_q, denied_d;

    // Memory port controls
    logic           wr_en;
    logic [IW-1:0]  wr_idx;
    logic           rd_en;
    logic [IW-1:0]  rd_idx;
    logic           rd_zero;            // load zero instead of memory (denied Get)

    logic a_fire;
    logic d_fire;

    // -----------------------------------------------------------------------
    // First-beat request decode
    // -----------------------------------------------------------------------
    logic [31:0]   offset;
    logic [IW-1:0] req_idx;
    logic [33:0]   req_last;
    logic [31:0]   align_mask;
    logic          op_put;
    logic          op_get;
    logic          op_data;
    logic          req_denied;
    logic [15:0]   req_beats_m1;

    assign offset     = auto_in_a_bits_address - BASE_ADDR;
    assign req_idx    = offset[IW+1:2];
    assign req_last   = {2'b00, auto_in_a_bits_address} + ((34'd1 << auto_in_a_bits_size) - 34'd1);
    assign align_mask = (32'd1 << auto_in_a_bits_size) - 32'd1;

    assign op_put  = (auto_in_a_bits_opcode == 3'd0) || (auto_in_a_bits_opcode == 3'd1);
    assign op_get  = (auto_in_a_bits_opcode == 3'd4);
    // Opcodes 0..3 carry a data payload and therefore one A beat per bus word,
    // even the ones we deny (Arithmetic/Logical).
    assign op_data = ~auto_in_a_bits_opcode[2];

    assign req_denied = ({28'd0, auto_in_a_bits_size} > 32'(MAX_SIZE))
                      || ((auto_in_a_bits_address & align_mask) != 32'd0)
                      || ({2'b00, auto_in_a_bits_address} < {2'b00, BASE_ADDR})
                      || (req_last > REGION_LAST)
                      || !(op_put || op_get);

    assign req_beats_m1 = (auto_in_a_bits_size <= 4'd2)
                        ? 16'd0
                        : (16'd1 << (auto_in_a_bits_size - 4'd2)) - 16'd1;

    // -----------------------------------------------------------------------
    // Handshakes
    // -----------------------------------------------------------------------
    assign auto_in_a_ready = reset && (state_q != S_RESP);
    assign auto_in_d_valid = (state_q == S_RESP);
    assign a_fire          = auto_in_a_valid && auto_in_a_ready;
    assign d_fire          = auto_in_d_valid && auto_in_d_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        source_d = source_q;
        size_d   = size_q;
        is_get_d = is_get_q;
        denied_d = denied_q;
        wr_en    = 1'b0;
        wr_idx   = idx_q;
        rd_en    = 1'b0;
        rd_idx   = idx_q;
        rd_zero  = denied_q;

        unique case (state_q)
            S_IDLE: begin
                if (a_fire) begin
                    source_d = auto_in_a_bits_source;
                    size_d   = auto_in_a_bits_size;
                    is_get_d = op_get;
                    denied_d = req_denied;
                    idx_d    = req_idx + IW'(1);
                    wr_idx   = req_idx;
                    wr_en    = op_put && !req_denied && !auto_in_a_bits_corrupt;
                    if (op_data && (req_beats_m1 != 16'd0)) begin
                        state_d = S_PUT_BURST;
                        cnt_d   = req_beats_m1;
                    end else if (op_get) begin
                        state_d = S_RESP;
                        cnt_d   = req_beats_m1;
                        rd_en   = 1'b1;
                        rd_idx  = req_idx;
                        rd_zero = req_denied;
                    end else begin
                        state_d = S_RESP;
                        cnt_d   = 16'd0;
                    end
                end
            end
            S_PUT_BURST: begin
                if (a_fire) begin
                    // Corrupt beats are dropped silently; the ack stays clean.
                    wr_en = !denied_q && !auto_in_a_bits_corrupt;
                    idx_d = idx_q + IW'(1);
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (d_fire) begin
                    if (is_get_q && (cnt_q != 16'd0)) begin
                        rd_en = 1'b1;
                        idx_d = idx_q + IW'(1);
                        cnt_d = cnt_q - 16'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            source_q <= '0;
            size_q   <= '0;
            is_get_q <= 1'b0;
            denied_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            source_q <= source_d;
            size_q   <= size_d;
            is_get_q <= is_get_d;
            denied_q <= denied_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage: one byte-wide RAM per lane so the mask maps onto independent
    // write enables. Contents are intentionally never reset; only the read
    // register (which drives d_data) is.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH_WORDS];
        logic [7:0] lane_rd_q;

        always_ff @(posedge clock) begin
            if (wr_en && auto_in_a_bits_mask[gi]) begin
                lane_mem[wr_idx] <= auto_in_a_bits_data[gi*8 +: 8];
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                lane_rd_q <= '0;
            end else if (rd_en) begin
                lane_rd_q <= rd_zero ? 8'd0 : lane_mem[rd_idx];
            end
        end

        assign auto_in_d_bits_data[gi*8 +: 8] = lane_rd_q;
    end

    // -----------------------------------------------------------------------
    // D channel fields
    // -----------------------------------------------------------------------
    assign auto_in_d_bits_opcode  = {2'b00, is_get_q};
    assign auto_in_d_bits_param   = 2'b00;
    assign auto_in_d_bits_size    = size_q;
    assign auto_in_d_bits_source  = source_q;
    assign auto_in_d_bits_sink    = 1'b0;
    assign auto_in_d_bits_denied  = denied_q;
    assign auto_in_d_bits_corrupt = denied_q && is_get_q;

    // Inputs/bits that carry no meaning for this endpoint.
    logic unused_bits;
    assign unused_bits = ^{auto_in_a_bits_param, offset[31:IW+2], offset[1:0]};

endmodule

// File: doc/tl_ul_sram_responder.md
Name: tl_ul_sram_responder

Overview:
- TileLink-UL manager endpoint: terminates A-channel requests and returns D-channel responses from an internal register-array memory.
- Sits at the slave end of a buffered TL link, on the far side of a TL buffer stage; serves as the on-chip scratch/test RAM.
- Supports Get, PutFullData and PutPartialData on a 32-bit bus with multi-beat bursts. Rejects everything else with a denied response.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the region.
- DEPTH_WORDS, 256, number of 32-bit words (power of 2).
- MAX_SIZE, 6, largest accepted lg2 transfer size (6 = 64 B = 16 beats).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- auto_in_a_ready  out  1  A accept.
- auto_in_a_valid  in  1  A beat valid.
- auto_in_a_bits_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get, others unsupported.
- auto_in_a_bits_param  in  3  ignored.
- auto_in_a_bits_size  in  4  lg2 bytes.
- auto_in_a_bits_source  in  4  requester id.
- auto_in_a_bits_address  in  32  byte address.
- auto_in_a_bits_mask  in  4  byte lanes.
- auto_in_a_bits_data  in  32  write data.
- auto_in_a_bits_corrupt  in  1  beat corrupt.
- auto_in_d_ready  in  1  D accept.
- auto_in_d_valid  out  1  D beat valid.
- auto_in_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData.
- auto_in_d_bits_param  out  2  always 0.
- auto_in_d_bits_size  out  4  echoes request size.
- auto_in_d_bits_source  out  4  echoes request source.
- auto_in_d_bits_sink  out  1  always 0.
- auto_in_d_bits_denied  out  1  request rejected.
- auto_in_d_bits_data  out  32  read data.
- auto_in_d_bits_corrupt  out  1  data invalid.

Behaviour:
- Reset (reset low, async):
  - State = IDLE, beat counter = 0.
  - auto_in_d_valid = 0; all d_bits = 0.
  - auto_in_a_ready forced 0 while reset is low.
  - Memory contents are not reset.
- Beat count: N = (size<=2) ? 1 : 2^(size-2).
  - Opcodes 0..3 carry N A beats; all other opcodes carry 1 A beat.
  - Get responses carry N D beats.
- Denied if any of:
  - size > MAX_SIZE;
  - address not aligned to 2^size;
  - any byte of [address, address+2^size-1] outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS-1];
  - opcode not in {0,1,4}.
  - The denied decision is made on the first A beat and held for the whole transaction.
- Word index = (address - BASE_ADDR)>>2, incremented by 1 per beat. Address bits of later A beats are ignored.
- FSM states: IDLE, PUT_BURST, RESP.
  - auto_in_a_ready = 1 in IDLE and PUT_BURST, 0 in RESP.
  - IDLE, on A fire (valid & ready):
    - Latch source, size, opcode and denied.
    - Put, not denied, a_corrupt = 0: write the beat under mask.
    - Multi-beat data opcode: go to PUT_BURST with counter = N-1.
    - Get: go to RESP, loading D with word[idx] and counter = N-1.
    - Otherwise: go to RESP with a single AccessAck.
  - PUT_BURST, on each A fire:
    - Write the beat, unless denied or a_corrupt.
    - Decrement counter; on the last beat go to RESP.
    - Beats with a_corrupt = 1 are skipped; the response is still not denied.
  - RESP:
    - d_valid = 1; all d_bits are held stable until d_ready.
    - On D fire with Get and counter != 0: load the next word, decrement counter, keep d_valid = 1 (back-to-back beats allowed).
    - On D fire otherwise: go to IDLE, d_valid = 0 the next cycle.
- D field rules:
  - Get → opcode 1. Put and unsupported opcodes → opcode 0.
  - Denied Get beats: data = 0, denied = 1, corrupt = 1.
  - Denied AccessAck: denied = 1, corrupt = 0.
  - Non-denied responses: denied = 0, corrupt = 0.
  - Sub-word Get (size 0..2) returns the full 32-bit word.
- Latency: d_valid rises the cycle after the final A beat is accepted. A new transaction can be accepted no earlier than the cycle after the last D beat fires (minimum 2 cycles per single-beat transaction).
- Simultaneous read/write: impossible by construction, since A is blocked while D is pending.
- Reset mid-operation: the burst is abandoned, partial writes already made are kept, and there is no response.

Test Plan:
- Hold reset low → a_ready=0, d_valid=0. Release → a_ready=1 on the first clock; d_valid stays 0.
- PutFull size 2, addr 0x10, data 0xDEADBEEF, mask 0xF, source 3 → next cycle D opcode 0, source 3, size 2, denied 0. Then Get size 2 at 0x10 → opcode 1, data 0xDEADBEEF.
- PutPartial at 0x10, mask 0x5, data 0x11223344 → Get returns 0xDE22BE44.
- PutFull size 4 at 0x40, beats 1,2,3,4 (a_ready held 1) → one AccessAck after beat 4. Get size 4 at 0x40 with d_ready toggling 1,0,1… → four D beats with data 1,2,3,4, stable while stalled; a_ready=0 throughout.
- Get size 2 at BASE+4*DEPTH_WORDS → denied=1, corrupt=1, data 0. Get size 3 at 0x4 → denied. Opcode 5 → AccessAck denied=1.
- Assert reset during beat 2 of a 4-beat Get → d_valid drops to 0 immediately. After release, a fresh Get at 0x40 returns 1.
